// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with one write port, two registered read ports and a clear sequencer.
// Compile-time option REGFILE_BYPASS_EN selects write-first forwarding; by default reads are read-first.
module regfile_2r1w #(
  parameter int                 DATA_W  = 32,
  parameter int                 DEPTH   = 32,
  parameter int                 ADDR_W  = 5,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren0,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              ren1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              clr,
  output logic              busy,
  output logic              dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // One bit wider than the address so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              clr_we;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd0_val, rd1_val;

  // clr is a one-edge request accepted only when busy is low; busy stays high
  // for exactly DEPTH cycles while entries 0..DEPTH-1 are overwritten in order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign busy      = (state_q == S_CLEAR);
  assign dbg_state = state_q;

  assign wr_en = !we_ && !busy && ({1'b0, waddr} < DEPTH_C);

  // wr_en and clr_we are mutually exclusive, so at most one entry updates per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
    end else begin
      if (wr_en) begin
        mem[waddr] <= wdata;
      end
      if (clr_we) begin
        mem[cnt_q[ADDR_W-1:0]] <= RST_VAL;
      end
    end
  end

  always_comb begin
    rd0_val = '0;
    if ({1'b0, raddr0} < DEPTH_C) begin
      rd0_val = mem[raddr0];
    end
`ifdef REGFILE_BYPASS_EN
    if (clr_we && ({1'b0, raddr0} == cnt_q)) begin
      rd0_val = RST_VAL;
    end
    if (wr_en && (raddr0 == waddr)) begin
      rd0_val = wdata;
    end
`endif
  end

  always_comb begin
    rd1_val = '0;
    if ({1'b0, raddr1} < DEPTH_C) begin
      rd1_val = mem[raddr1];
    end
`ifdef REGFILE_BYPASS_EN
    if (clr_we && ({1'b0, raddr1} == cnt_q)) begin
      rd1_val = RST_VAL;
    end
    if (wr_en && (raddr1 == waddr)) begin
      rd1_val = wdata;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (ren0) begin
        rdata0 <= rd0_val;
      end
      if (ren1) begin
        rdata1 <= rd1_val;
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: randomized and directed checks of regfile_2r1w against an array-based reference model.
// A second instance with DEPTH=20 covers out-of-range addressing.
module tb_regfile_2r1w;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int SDEP  = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance
  logic          we_;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          ren0, ren1, clr;
  logic [AW-1:0] raddr0, raddr1;
  logic [DW-1:0] rdata0, rdata1;
  logic          busy, dbg_state;

  // small instance
  logic          s_we_;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic          s_ren0, s_ren1, s_clr;
  logic [AW-1:0] s_raddr0, s_raddr1;
  logic [DW-1:0] s_rdata0, s_rdata1;
  logic          s_busy, s_dbg_state;

  regfile_2r1w #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RST_VAL('0)) dut (
    .clk(clk), .reset(reset), .we_(we_), .waddr(waddr), .wdata(wdata),
    .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1),
    .clr(clr), .busy(busy), .dbg_state(dbg_state)
  );

  regfile_2r1w #(.DATA_W(DW), .DEPTH(SDEP), .ADDR_W(AW), .RST_VAL('0)) dut_small (
    .clk(clk), .reset(reset), .we_(s_we_), .waddr(s_waddr), .wdata(s_wdata),
    .ren0(s_ren0), .raddr0(s_raddr0), .rdata0(s_rdata0),
    .ren1(s_ren1), .raddr1(s_raddr1), .rdata1(s_rdata1),
    .clr(s_clr), .busy(s_busy), .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_idx;      // -1 when idle, else next entry to be cleared
  logic [DW-1:0] exp0, exp1;
  logic [DW-1:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_clr_idx = -1;
    exp0 = '0;
    exp1 = '0;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit wr_ok);
    if (int'(a) >= DEPTH) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (a == waddr)) return wdata;
    if ((m_clr_idx >= 0) && (int'(a) == m_clr_idx)) return '0;
`endif
    return m_mem[a];
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit wr_ok;
    wr_ok = (we_ == 1'b0) && (m_clr_idx < 0) && (int'(waddr) < DEPTH);
    if (ren0) exp0 = model_read(raddr0, wr_ok);
    if (ren1) exp1 = model_read(raddr1, wr_ok);
    if (wr_ok) m_mem[waddr] = wdata;
    if (m_clr_idx >= 0) begin
      m_mem[m_clr_idx] = '0;
      m_clr_idx++;
      if (m_clr_idx == DEPTH) m_clr_idx = -1;
    end else if (clr) begin
      m_clr_idx = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    we_ = 1'b1; waddr = '0; wdata = '0;
    ren0 = 1'b0; raddr0 = '0; ren1 = 1'b0; raddr1 = '0; clr = 1'b0;
  endtask

  task automatic set_small_idle();
    s_we_ = 1'b1; s_waddr = '0; s_wdata = '0;
    s_ren0 = 1'b0; s_raddr0 = '0; s_ren1 = 1'b0; s_raddr1 = '0; s_clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    we_ = 1'b0; waddr = AW'(7); wdata = $urandom() | 32'h1;
    tick();
    we_ = 1'b1; ren0 = 1'b1; raddr0 = AW'(7); ren1 = 1'b1; raddr1 = AW'(7);
    tick();
    checks++;
    if (rdata0 !== exp0) begin
      failures++; $display("FAIL reset_pre_rd0 got=%h exp=%h", rdata0, exp0);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (rdata0 !== '0 || rdata1 !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_async got rd0=%h rd1=%h busy=%b exp 0/0/0", rdata0, rdata1, busy);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ren0 = 1'b1; raddr0 = AW'(i); ren1 = 1'b1; raddr1 = AW'(DEPTH - 1 - i);
      tick();
      checks++;
      if (rdata0 !== '0 || rdata1 !== '0) begin
        failures++; $display("FAIL reset_read addr=%0d got rd0=%h rd1=%h exp 0", i, rdata0, rdata1);
      end
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] e0, e1;
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      we_ = 1'b0; waddr = AW'(i); wdata = DW'(i + 1);
      tick();
    end
    we_ = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ren0 = 1'b1; raddr0 = AW'(i); ren1 = 1'b1; raddr1 = AW'(DEPTH - 1 - i);
      exp_q.push_back(DW'(i + 1));
      exp_q.push_back(DW'(DEPTH - i));
      tick();
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      checks++;
      if (rdata0 !== e0 || rdata1 !== e1) begin
        failures++; $display("FAIL fill_read i=%0d got rd0=%h rd1=%h exp %h %h", i, rdata0, rdata1, e0, e1);
      end
    end
    ren0 = 1'b0; ren1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      raddr0 = AW'($urandom_range(DEPTH - 1, 0));
      raddr1 = AW'($urandom_range(DEPTH - 1, 0));
      tick();
      checks++;
      if (rdata0 !== DW'(DEPTH) || rdata1 !== DW'(1)) begin
        failures++; $display("FAIL fill_hold k=%0d got rd0=%h rd1=%h exp %h %h", k, rdata0, rdata1, DEPTH, 1);
      end
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    set_idle();
    we_ = 1'b0; waddr = AW'(5); wdata = 32'h11;
    tick();
    wdata = 32'hAA; ren0 = 1'b1; raddr0 = AW'(5);
    tick();
`ifdef REGFILE_BYPASS_EN
    want = 32'hAA;
`else
    want = 32'h11;
`endif
    checks++;
    if (rdata0 !== want) begin
      failures++; $display("FAIL collision_same_edge got=%h exp=%h", rdata0, want);
    end
    we_ = 1'b1;
    tick();
    checks++;
    if (rdata0 !== 32'hAA) begin
      failures++; $display("FAIL collision_after got=%h exp=%h", rdata0, 32'hAA);
    end
    for (int k = 0; k < 24; k++) begin
      we_ = 1'b0; waddr = AW'($urandom_range(DEPTH - 1, 0)); wdata = $urandom();
      ren0 = 1'b1; raddr0 = waddr;
      ren1 = 1'b1; raddr1 = (k % 2 == 0) ? waddr : AW'($urandom_range(DEPTH - 1, 0));
      tick();
      checks++;
      if (rdata0 !== exp0 || rdata1 !== exp1) begin
        failures++; $display("FAIL collision_rand k=%0d got rd0=%h rd1=%h exp %h %h", k, rdata0, rdata1, exp0, exp1);
      end
    end
  endtask

  task automatic test_clear();
    int n;
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      we_ = 1'b0; waddr = AW'(i); wdata = 32'hFFFF_FFFF;
      tick();
    end
    set_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = (busy === 1'b1) ? 1 : 0;
    while (busy === 1'b1 && n < 100) begin
      we_  = (n == 10) ? 1'b0 : 1'b1;
      waddr = AW'(3); wdata = 32'h55;
      clr  = (n == 15) ? 1'b1 : 1'b0;
      ren0 = 1'b1; raddr0 = AW'($urandom_range(DEPTH - 1, 0));
      ren1 = 1'b1; raddr1 = AW'($urandom_range(DEPTH - 1, 0));
      tick();
      checks++;
      if (rdata0 !== exp0 || rdata1 !== exp1 || busy !== (m_clr_idx >= 0)) begin
        failures++; $display("FAIL clear_busy_rd n=%0d got rd0=%h rd1=%h busy=%b exp %h %h %b",
                             n, rdata0, rdata1, busy, exp0, exp1, (m_clr_idx >= 0));
      end
      if (busy === 1'b1) n++;
    end
    checks++;
    if (n != DEPTH) begin
      failures++; $display("FAIL clear_busy_len got=%0d exp=%0d", n, DEPTH);
    end
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      ren0 = 1'b1; raddr0 = AW'(i); ren1 = 1'b1; raddr1 = AW'(DEPTH - 1 - i);
      tick();
      checks++;
      if (rdata0 !== '0 || rdata1 !== '0) begin
        failures++; $display("FAIL clear_after addr=%0d got rd0=%h rd1=%h exp 0", i, rdata0, rdata1);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] want;
    set_idle();
    for (int i = 0; i < 8; i++) begin
      we_ = 1'b0; waddr = AW'($urandom_range(DEPTH - 1, 0)); wdata = $urandom() | 32'h1;
      tick();
    end
    set_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL midclr_busy_before got=%b exp=1", busy);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== 1'b0) begin
      failures++; $display("FAIL midclr_async got busy=%b state=%b exp 0 0", busy, dbg_state);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    we_ = 1'b0; waddr = AW'(20); wdata = 32'h1234;
    tick();
    we_ = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ren0 = 1'b1; raddr0 = AW'(i); ren1 = 1'b1; raddr1 = AW'(i);
      tick();
      want = (i == 20) ? 32'h1234 : 32'h0;
      checks++;
      if (rdata0 !== want || rdata1 !== want) begin
        failures++; $display("FAIL midclr_read addr=%0d got rd0=%h rd1=%h exp %h", i, rdata0, rdata1, want);
      end
    end
  endtask

  task automatic test_random();
    set_idle();
    for (int c = 0; c < 400; c++) begin
      we_    = ($urandom_range(1, 0) == 0);
      waddr  = AW'($urandom_range(DEPTH - 1, 0));
      wdata  = $urandom();
      ren0   = ($urandom_range(3, 0) != 0);
      raddr0 = ($urandom_range(3, 0) == 0) ? waddr : AW'($urandom_range(DEPTH - 1, 0));
      ren1   = ($urandom_range(3, 0) != 0);
      raddr1 = ($urandom_range(3, 0) == 0) ? waddr : AW'($urandom_range(DEPTH - 1, 0));
      clr    = ($urandom_range(59, 0) == 0);
      tick();
      checks++;
      if (rdata0 !== exp0 || rdata1 !== exp1 || busy !== (m_clr_idx >= 0) || dbg_state !== (m_clr_idx >= 0)) begin
        failures++; $display("FAIL random c=%0d got rd0=%h rd1=%h busy=%b st=%b exp %h %h %b",
                             c, rdata0, rdata1, busy, dbg_state, exp0, exp1, (m_clr_idx >= 0));
      end
    end
    set_idle();
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] want;
    set_idle();
    set_small_idle();
    for (int i = 0; i < SDEP; i++) begin
      s_we_ = 1'b0; s_waddr = AW'(i); s_wdata = DW'(32'h100 + i);
      tick();
    end
    s_waddr = AW'(25); s_wdata = 32'h77;
    tick();
    s_we_ = 1'b1;
    s_ren0 = 1'b1; s_raddr0 = AW'(0); s_ren1 = 1'b1; s_raddr1 = AW'(0);
    tick();
    s_raddr0 = AW'(25); s_raddr1 = AW'(25);
    tick();
    checks++;
    if (s_rdata0 !== '0 || s_rdata1 !== '0) begin
      failures++; $display("FAIL oor_read got rd0=%h rd1=%h exp 0", s_rdata0, s_rdata1);
    end
    for (int i = 0; i < SDEP; i++) begin
      s_raddr0 = AW'(i); s_raddr1 = AW'(SDEP - 1 - i);
      tick();
      want = DW'(32'h100 + i);
      checks++;
      if (s_rdata0 !== want || s_rdata1 !== DW'(32'h100 + SDEP - 1 - i)) begin
        failures++; $display("FAIL oor_entries i=%0d got rd0=%h rd1=%h exp %h %h",
                             i, s_rdata0, s_rdata1, want, DW'(32'h100 + SDEP - 1 - i));
      end
    end
    set_small_idle();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    set_idle();
    set_small_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_fill();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    test_random();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised successor to the single-port register file: one write port and two independent registered read ports, plus a hardware clear sequencer that zeroes the array without software loops. Intended as the general-purpose register store for datapath blocks that need two operands per cycle. Single clock domain.

Parameters:
DATA_W, 32, width of each entry in bits
DEPTH, 32, number of entries; any value 2..256, need not be a power of two
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH
RST_VAL, 0, value loaded into every entry by reset and by the clear sequence

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous reset, active-high
we_  input  1  write strobe, active-low
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
ren0  input  1  read enable, port 0, active-high
raddr0  input  ADDR_W  read address, port 0
rdata0  output  DATA_W  registered read data, port 0
ren1  input  1  read enable, port 1, active-high
raddr1  input  ADDR_W  read address, port 1
rdata1  output  DATA_W  registered read data, port 1
clr  input  1  clear request, active-high, sampled on clock edge
busy  output  1  high while clear sequence is running

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset asserted: every entry = RST_VAL, rdata0 = rdata1 = 0, busy = 0, FSM = IDLE, clear counter = 0. Takes effect immediately, without waiting for a clock edge.
- Write: at an edge with we_=0, busy=0 and waddr<DEPTH, mem[waddr] <= wdata. waddr>=DEPTH is dropped silently. While busy=1, writes are dropped.
- Read: 1-cycle latency. At an edge with renN=1, rdataN <= mem[raddrN]. With renN=0, rdataN holds its value. raddrN>=DEPTH returns 0. Both ports may read the same address in the same cycle. Reads remain legal while busy=1 and return current contents.
- Same-edge read/write to one address: returns the old value (read-first), unless the optional feature is compiled in.
- Clear FSM has two states:
  - IDLE: clr=1 at an edge -> CLEAR, cnt <= 0, busy <= 1. No array write occurs at that edge.
  - CLEAR: at each edge mem[cnt] <= RST_VAL and cnt <= cnt+1. At the edge where cnt==DEPTH-1, write the final entry, go to IDLE and set busy <= 0. busy is therefore high for exactly DEPTH cycles.
- clr while in CLEAR: ignored; does not restart the count.
- clr and a valid write on the same edge in IDLE: the write is performed, then the clear sequence overwrites it.
- reset during CLEAR: the sequence aborts; reset state as above.
- Counter width is ADDR_W+1 internally, so DEPTH = 2**ADDR_W does not wrap early.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-first forwarding. If a write is performed at an edge (we_=0, busy=0, waddr<DEPTH) and renN=1 with raddrN==waddr, then rdataN <= wdata. During CLEAR, a read of address cnt returns RST_VAL. Forwarding applies to both ports independently.
- Undefined: read-first. rdataN gets the pre-write array contents. No forwarding muxes are generated.

Test Plan:
- Reset then read: assert reset mid-cycle, release; read addr 0..31 on both ports -> every rdata = 0; rdata0/rdata1 go to 0 asynchronously while reset is high.
- Fill/readback: write i+1 to addr i for i=0..31, then port0 reads i while port1 reads 31-i -> one cycle later rdata0 = i+1 and rdata1 = 32-i; rdata holds when ren=0.
- Collision: mem[5]=0x11; same edge we_=0 waddr=5 wdata=0xAA, ren0=1 raddr0=5 -> rdata0 = 0x11 without REGFILE_BYPASS_EN, 0xAA with it; next read of addr 5 -> 0xAA in both builds.
- Clear sequence: fill with 0xFFFFFFFF, pulse clr for 1 cycle -> busy high for exactly 32 cycles; a write of 0x55 to addr 3 during busy is dropped; afterwards all entries read 0.
- Reset mid-clear: start clear, assert reset after 10 cycles -> busy=0 immediately; a later write/read of addr 20 = 0x1234 works; all other entries read 0.
- Out of range: with DEPTH=20, ADDR_W=5, write 0x77 to addr 25 and read addr 25 -> rdata = 0; entries 0..19 are unchanged.
